// File: rtl/heater_pkg.sv
// heater_pkg: shared state encoding, key indices and seconds width for the bath heater controller.
package heater_pkg;
    typedef enum logic [2:0] {
        OFF     = 3'd0,
        IDLE    = 3'd1,
        PREFAN  = 3'd2,
        HEAT    = 3'd3,
        OVERRUN = 3'd4
    } state_t;
    localparam int KEY_PWR   = 0;
    localparam int KEY_HEAT  = 1;
    localparam int KEY_FAN   = 2;
    localparam int KEY_LIGHT = 3;
    localparam int SEC_W     = 12;
endpackage

// File: rtl/heater_ctrl_sec_timer.sv
// sec_timer: prescaler producing a 1 s tick plus a seconds counter, both cleared by clr.
module sec_timer
    import heater_pkg::*;
#(
    parameter int TICK_CYCLES = 50000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    output logic             tick,
    output logic [SEC_W-1:0] sec
);
    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    logic [PW-1:0]    r_pre;
    logic [SEC_W-1:0] r_sec;
    assign tick = (r_pre == PW'(TICK_CYCLES - 1));
    assign sec  = r_sec;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre <= '0;
            r_sec <= '0;
        end else if (clr) begin
            r_pre <= '0;
            r_sec <= '0;
        end else begin
            r_pre <= tick ? '0 : r_pre + PW'(1);
            r_sec <= tick ? r_sec + SEC_W'(1) : r_sec;
        end
    end
endmodule

// File: rtl/heater_ctrl.sv
// heater_ctrl: bath heater mode FSM with fan pre-run/overrun interlocks and heat auto-off.
// Optional key beep output enabled by defining HEATER_BEEP_EN.
module heater_ctrl
    import heater_pkg::*;
#(
    parameter int TICK_CYCLES = 50000000,
    parameter int PREFAN_S    = 3,
    parameter int OVERRUN_S   = 30,
    parameter int AUTO_OFF_S  = 1800
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       key_pulse,
    output logic             heat_on,
    output logic             fan_on,
    output logic             light_on,
    output logic [2:0]       state,
    output logic [SEC_W-1:0] remain_s
`ifdef HEATER_BEEP_EN
    ,
    output logic             beep
`endif
);
    state_t           r_state;
    state_t           w_nxt;
    logic             r_heat, r_fan, r_light, r_off_pend;
    logic [SEC_W-1:0] r_remain;
    logic             w_tick, w_clr, w_acc;
    logic [SEC_W-1:0] w_sec;
    logic             w_pwr, w_heat, w_fan, w_light, w_rearm;
    logic             w_pre_done, w_heat_done, w_ovr_done;
    // power > heat > fan; light is independent
    assign w_pwr   = key_pulse[KEY_PWR];
    assign w_heat  = key_pulse[KEY_HEAT] & ~w_pwr;
    assign w_fan   = key_pulse[KEY_FAN] & ~key_pulse[KEY_PWR] & ~key_pulse[KEY_HEAT];
    assign w_light = key_pulse[KEY_LIGHT];
    assign w_rearm = w_heat & ~r_off_pend;
    // >= rather than == so an expiry discarded by a key fires on the next tick
    assign w_pre_done  = w_tick && (w_sec >= SEC_W'(PREFAN_S - 1));
    assign w_ovr_done  = w_tick && (w_sec >= SEC_W'(OVERRUN_S - 1));
    assign w_heat_done = w_tick && (r_remain == SEC_W'(1));
    assign w_clr = (w_nxt != r_state);
    sec_timer #(.TICK_CYCLES(TICK_CYCLES)) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (w_clr),
        .tick(w_tick),
        .sec (w_sec)
    );
    always_comb begin
        w_nxt = r_state;
        w_acc = 1'b0;
        case (r_state)
            OFF: begin
                w_nxt = w_pwr ? IDLE : OFF;
                w_acc = w_pwr;
            end
            IDLE: begin
                w_nxt = w_pwr ? OFF : w_heat ? PREFAN : IDLE;
                w_acc = w_pwr | w_heat | w_fan | w_light;
            end
            PREFAN: begin
                w_nxt = w_pwr ? OFF : w_heat ? IDLE : w_pre_done ? HEAT : PREFAN;
                w_acc = w_pwr | w_heat | w_light;
            end
            HEAT: begin
                w_nxt = (w_pwr | w_heat | w_heat_done) ? OVERRUN : HEAT;
                w_acc = w_pwr | w_heat | w_light;
            end
            OVERRUN: begin
                w_nxt = w_rearm ? PREFAN : w_pwr ? OVERRUN :
                        w_ovr_done ? (r_off_pend ? OFF : IDLE) : OVERRUN;
                w_acc = w_pwr | w_rearm | w_light;
            end
            default: w_nxt = OFF;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= OFF;
            r_heat     <= 1'b0;
            r_fan      <= 1'b0;
            r_light    <= 1'b0;
            r_off_pend <= 1'b0;
            r_remain   <= '0;
        end else begin
            r_state    <= w_nxt;
            r_heat     <= (w_nxt == HEAT);
            r_fan      <= (w_nxt == PREFAN || w_nxt == HEAT || w_nxt == OVERRUN) ? 1'b1 :
                          (w_nxt == IDLE && r_state == IDLE) ? r_fan ^ w_fan : 1'b0;
            r_light    <= (w_nxt == OFF || r_state == OFF) ? 1'b0 : r_light ^ w_light;
            r_off_pend <= (w_nxt == OFF || w_nxt == IDLE) ? 1'b0 :
                          ((r_state == HEAT || r_state == OVERRUN) && w_pwr) ? 1'b1 : r_off_pend;
            r_remain   <= (w_nxt != HEAT) ? '0 :
                          (r_state != HEAT) ? SEC_W'(AUTO_OFF_S) :
                          w_tick ? r_remain - SEC_W'(1) : r_remain;
        end
    end
    assign heat_on  = r_heat;
    assign fan_on   = r_fan;
    assign light_on = r_light;
    assign state    = r_state;
    assign remain_s = r_remain;
`ifdef HEATER_BEEP_EN
    localparam int BEEP_CYCLES = (TICK_CYCLES / 10 > 0) ? TICK_CYCLES / 10 : 1;
    localparam int BW = $clog2(BEEP_CYCLES + 1);
    logic          r_beep;
    logic [BW-1:0] r_bcnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beep <= 1'b0;
            r_bcnt <= '0;
        end else if (w_acc) begin
            r_beep <= 1'b1;
            r_bcnt <= BW'(BEEP_CYCLES - 1);
        end else if (r_bcnt != '0) begin
            r_bcnt <= r_bcnt - BW'(1);
        end else begin
            r_beep <= 1'b0;
        end
    end
    assign beep = r_beep;
`else
    logic w_unused;
    assign w_unused = w_acc;
`endif
endmodule

// File: tb/tb_heater_ctrl.sv
// tb_heater_ctrl: directed plus random key stimulus against a seconds-level behavioural model.
module tb_heater_ctrl;
    localparam int T   = 10;
    localparam int PRE = 2;
    localparam int OVR = 3;
    localparam int AUT = 5;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  key_pulse = 4'b0;
    logic        heat_on, fan_on, light_on;
    logic [2:0]  state;
    logic [11:0] remain_s;
`ifdef HEATER_BEEP_EN
    logic        beep;
`endif
    int n_chk  = 0;
    int n_fail = 0;
    int m_state, m_cyc;
    bit m_pend, m_fan, m_light;
    heater_ctrl #(.TICK_CYCLES(T), .PREFAN_S(PRE), .OVERRUN_S(OVR), .AUTO_OFF_S(AUT)) dut (
        .clk      (clk),
        .rst      (rst),
        .key_pulse(key_pulse),
        .heat_on  (heat_on),
        .fan_on   (fan_on),
        .light_on (light_on),
        .state    (state),
        .remain_s (remain_s)
`ifdef HEATER_BEEP_EN
        ,
        .beep     (beep)
`endif
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic model_reset();
        m_state = 0;
        m_cyc   = 0;
        m_pend  = 0;
        m_fan   = 0;
        m_light = 0;
    endtask
    // one clock of the reference: mode, seconds elapsed in mode, flags
    task automatic model_step(input logic [3:0] k);
        int  ns   = m_state;
        bit  p    = k[0];
        bit  h    = k[1] & ~k[0];
        bit  f    = k[2] & ~k[0] & ~k[1];
        bit  sec_end = ((m_cyc + 1) % T) == 0;
        int  secs = (m_cyc + 1) / T;
        case (m_state)
            0: if (p) ns = 1;
            1: begin
                if (p) ns = 0;
                else if (h) ns = 2;
                else if (f) m_fan = ~m_fan;
            end
            2: begin
                if (p) ns = 0;
                else if (h) ns = 1;
                else if (sec_end && secs >= PRE) ns = 3;
            end
            3: begin
                if (p || h || (sec_end && secs >= AUT)) ns = 4;
                if (p) m_pend = 1;
            end
            default: begin
                if (h && !m_pend) ns = 2;
                else if (p) m_pend = 1;
                else if (sec_end && secs >= OVR) ns = m_pend ? 0 : 1;
            end
        endcase
        if (m_state != 0) m_light = m_light ^ k[3];
        if (ns == 0) begin
            m_light = 0;
            m_fan   = 0;
            m_pend  = 0;
        end
        if (ns == 1 && m_state != 1) begin
            m_fan  = 0;
            m_pend = 0;
        end
        if (ns >= 2) m_fan = 1;
        m_cyc   = (ns != m_state) ? 0 : m_cyc + 1;
        m_state = ns;
    endtask
    task automatic step(input logic [3:0] k);
        @(negedge clk);
        key_pulse = k;
        @(posedge clk);
        model_step(k);
        #1;
        chk("state", int'(state), m_state);
        chk("heat_on", int'(heat_on), int'(m_state == 3));
        chk("fan_on", int'(fan_on), int'(m_fan));
        chk("light_on", int'(light_on), int'(m_light));
        chk("remain_s", int'(remain_s), (m_state == 3) ? AUT - m_cyc / T : 0);
    endtask
    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", int'(state), 0);
        chk("rst_relays", int'({heat_on, fan_on, light_on}), 0);
        chk("rst_remain", int'(remain_s), 0);
        @(negedge clk);
        rst = 1'b0;
        step(4'b0001);
        chk("pwr_idle", int'(state), 1);
`ifdef HEATER_BEEP_EN
        chk("beep_on", int'(beep), 1);
        step(4'b0000);
        chk("beep_off", int'(beep), 0);
        step(4'b0100);
        step(4'b0000);
        chk("beep_ignored", int'(beep), 0);
`endif
        step(4'b1000);
        chk("light_1", int'(light_on), 1);
        step(4'b1000);
        chk("light_0", int'(light_on), 0);
        step(4'b0010);
        repeat (19) step(4'b0000);
        chk("prefan_end", int'(state), 2);
        step(4'b0000);
        chk("heat_entry", int'(remain_s), AUT);
        repeat (90) step(4'b0000);
        chk("auto_off_idle", int'(state), 1);
        step(4'b0010);
        repeat (22) step(4'b0000);
        step(4'b1001);
        chk("pwr_overrun", int'(state), 4);
        step(4'b0010);
        chk("heat_ignored", int'(state), 4);
        repeat (35) step(4'b0000);
        chk("pend_off", int'(state), 0);
        step(4'b0001);
        step(4'b0011);
        chk("pwr_beats_heat", int'(state), 0);
        step(4'b0001);
        step(4'b1100);
        chk("fan_light", int'({fan_on, light_on}), 3);
        step(4'b0010);
        repeat (25) step(4'b0000);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_relays", int'({heat_on, fan_on, light_on}), 0);
        chk("async_rst_state", int'(state), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (4000) step(($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
